// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared UART types and constants (transmitter and receiver).
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam logic [2:0] C_ST_IDLE   = 3'd0;
    localparam logic [2:0] C_ST_START  = 3'd1;
    localparam logic [2:0] C_ST_DATA   = 3'd2;
    localparam logic [2:0] C_ST_PARITY = 3'd3;
    localparam logic [2:0] C_ST_STOP   = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE   = C_ST_IDLE,
        ST_START  = C_ST_START,
        ST_DATA   = C_ST_DATA,
        ST_PARITY = C_ST_PARITY,
        ST_STOP   = C_ST_STOP
    } uart_state_e;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // Bits needed to hold the values 0..n-1.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_bit_timer.sv
`default_nettype none
// ============================================================================
//  Module      : uart_bit_timer
//  Description : Counts oversample ticks and flags the last tick of each bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int OSR = 16
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    input  logic i_clear,
    output logic o_bit_end
);

    localparam int              C_CW   = cnt_width(OSR);
    localparam logic [C_CW-1:0] C_LAST = C_CW'(OSR - 1);
    localparam logic [C_CW-1:0] C_ONE  = C_CW'(1);

    logic [C_CW-1:0] r_cnt_q;
    logic [C_CW-1:0] w_cnt_d;
    logic            w_bit_end;

    // The bit-end flag is combinational so the FSM advances on the same edge
    // as the OSR-th tick.
    always_comb begin
        w_cnt_d   = r_cnt_q;
        w_bit_end = 1'b0;
        if (i_clear) begin
            w_cnt_d = '0;
        end else if (i_en) begin
            if (r_cnt_q == C_LAST) begin
                w_cnt_d   = '0;
                w_bit_end = 1'b1;
            end else begin
                w_cnt_d = r_cnt_q + C_ONE;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt_q <= '0;
        end else begin
            r_cnt_q <= w_cnt_d;
        end
    end

    assign o_bit_end = w_bit_end;

endmodule
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx
//  Description : Oversample-timed UART transmitter with optional parity.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx
    import uart_pkg::*;
#(
    parameter int OSR       = 16,
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 2,
    parameter int PARITY    = 0
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_en,
    input  logic                 i_start,
    input  logic [DATA_BITS-1:0] i_data,
    output logic                 o_tx,
    output logic                 o_ready,
    output logic                 o_done
);

    localparam int              C_BMAX      = (DATA_BITS > STOP_BITS) ? DATA_BITS : STOP_BITS;
    localparam int              C_BW        = cnt_width(C_BMAX);
    localparam logic [C_BW-1:0] C_LAST_DATA = C_BW'(DATA_BITS - 1);
    localparam logic [C_BW-1:0] C_LAST_STOP = C_BW'(STOP_BITS - 1);
    localparam logic [C_BW-1:0] C_ONE       = C_BW'(1);
    localparam logic            C_HAS_PAR   = (PARITY != PAR_NONE);
    localparam logic            C_ODD       = (PARITY == PAR_ODD);

    generate
        if (OSR < 2 || DATA_BITS < 5 || DATA_BITS > 9 || STOP_BITS < 1 ||
            STOP_BITS > 2 || PARITY < PAR_NONE || PARITY > PAR_EVEN) begin : g_bad_params
            $error("uart_tx: invalid parameter set");
        end
    endgenerate

    uart_state_e          r_state_q, w_state_d;
    logic [DATA_BITS-1:0] r_shift_q, w_shift_d;
    logic [C_BW-1:0]      r_bit_q,   w_bit_d;
    logic                 r_par_q,   w_par_d;
    logic                 r_tx_q,    w_tx_d;
    logic                 r_ready_q, w_ready_d;
    logic                 r_done_q,  w_done_d;
    logic                 w_accept;
    logic                 w_bit_end;
    logic                 w_clear;

    assign w_accept = i_start && r_ready_q;
    // Holding the timer clear while idle means a tick coinciding with
    // acceptance is not counted.
    assign w_clear  = (r_state_q == ST_IDLE);

    uart_bit_timer #(
        .OSR (OSR)
    ) u_bit_timer (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_en      (i_en),
        .i_clear   (w_clear),
        .o_bit_end (w_bit_end)
    );

    always_comb begin
        w_state_d = r_state_q;
        w_shift_d = r_shift_q;
        w_bit_d   = r_bit_q;
        w_par_d   = r_par_q;
        w_tx_d    = r_tx_q;
        w_ready_d = r_ready_q;
        w_done_d  = 1'b0;
        case (r_state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_d = ST_START;
                    w_shift_d = i_data;
                    w_par_d   = (^i_data) ^ C_ODD;
                    w_bit_d   = '0;
                    w_tx_d    = 1'b0;
                    w_ready_d = 1'b0;
                end
            end
            ST_START: begin
                if (w_bit_end) begin
                    w_state_d = ST_DATA;
                    w_bit_d   = '0;
                    w_tx_d    = r_shift_q[0];
                end
            end
            ST_DATA: begin
                if (w_bit_end) begin
                    w_shift_d = {1'b0, r_shift_q[DATA_BITS-1:1]};
                    if (r_bit_q == C_LAST_DATA) begin
                        w_bit_d = '0;
                        if (C_HAS_PAR) begin
                            w_state_d = ST_PARITY;
                            w_tx_d    = r_par_q;
                        end else begin
                            w_state_d = ST_STOP;
                            w_tx_d    = 1'b1;
                        end
                    end else begin
                        w_bit_d = r_bit_q + C_ONE;
                        w_tx_d  = r_shift_q[1];
                    end
                end
            end
            ST_PARITY: begin
                if (w_bit_end) begin
                    w_state_d = ST_STOP;
                    w_bit_d   = '0;
                    w_tx_d    = 1'b1;
                end
            end
            ST_STOP: begin
                if (w_bit_end) begin
                    if (r_bit_q == C_LAST_STOP) begin
                        w_state_d = ST_IDLE;
                        w_bit_d   = '0;
                        w_ready_d = 1'b1;
                        w_done_d  = 1'b1;
                    end else begin
                        w_bit_d = r_bit_q + C_ONE;
                    end
                    w_tx_d = 1'b1;
                end
            end
            default: begin
                w_state_d = ST_IDLE;
                w_bit_d   = '0;
                w_tx_d    = 1'b1;
                w_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state_q <= ST_IDLE;
            r_shift_q <= '0;
            r_bit_q   <= '0;
            r_par_q   <= 1'b0;
            r_tx_q    <= 1'b1;
            r_ready_q <= 1'b1;
            r_done_q  <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_shift_q <= w_shift_d;
            r_bit_q   <= w_bit_d;
            r_par_q   <= w_par_d;
            r_tx_q    <= w_tx_d;
            r_ready_q <= w_ready_d;
            r_done_q  <= w_done_d;
        end
    end

    assign o_tx    = r_tx_q;
    assign o_ready = r_ready_q;
    assign o_done  = r_done_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx
//  Description : Directed self-checking bench for uart_tx (four configurations).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx;

    // Instances: 0 = no parity, 1 = odd, 2 = even (OSR 16); 3 = no parity, OSR 4.
    logic       clk = 1'b0;
    logic       rst;
    logic       en    [4];
    logic       start [4];
    logic [7:0] data  [4];
    logic       tx    [4];
    logic       ready [4];
    logic       done  [4];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        uart_tx #(
            .OSR       (g == 3 ? 4 : 16),
            .DATA_BITS (8),
            .STOP_BITS (2),
            .PARITY    (g == 1 ? 1 : (g == 2 ? 2 : 0))
        ) u_dut (
            .i_clk   (clk),
            .i_rst   (rst),
            .i_en    (en[g]),
            .i_start (start[g]),
            .i_data  (data[g]),
            .o_tx    (tx[g]),
            .o_ready (ready[g]),
            .o_done  (done[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Sends one frame on instance k and checks it bit by bit at mid-bit ticks.
    // par: -1 none, else the hand-computed parity bit. mode: 0 dense enable,
    // 1 enable every 4th cycle, 2 as 1 plus a 100-cycle enable gap.
    // inj_c: cycle for a rejected start of 0x3C. rst_c/rst_len: abort by reset.
    // chain: return in the done cycle without advancing the clock.
    task automatic run_frame(input int k, input logic [7:0] d, input int par,
                             input int osr, input int mode, input int inj_c,
                             input int rst_c, input int rst_len,
                             input int exp_done, input bit chain);
        logic [15:0] fr;
        int          nb;
        int          t;
        int          low;
        int          cyc;
        bit          got_done;
        logic        en_now;
        logic        hold_tx;
        nb = (par >= 0) ? 12 : 11;
        fr = 16'hFFFF;
        fr[0] = 1'b0;
        fr[8:1] = d;
        if (par >= 0) fr[9] = par[0];
        hold_tx = 1'b0;
        chk($sformatf("k%0d_ready_before_%h", k, d), 32'(ready[k]), 1);
        start[k] = 1'b1;
        data[k]  = d;
        en[k]    = (mode == 0);
        @(negedge clk);
        start[k] = 1'b0;
        cyc = 1;
        t = 0;
        low = 0;
        got_done = 1'b0;
        chk($sformatf("k%0d_start_bit_%h", k, d), 32'(tx[k]), 0);
        if (!ready[k]) low++;
        for (int c = 0; c < 600; c++) begin
            if (mode == 0) en_now = 1'b1;
            else en_now = ((c + 1) % 4 == 0) && !(mode == 2 && c >= 80 && c < 180);
            en[k]    = en_now;
            start[k] = (c == inj_c);
            data[k]  = (c == inj_c) ? 8'h3C : d;
            rst      = (rst_c >= 0 && c >= rst_c && c < rst_c + rst_len);
            @(negedge clk);
            cyc++;
            if (rst_c >= 0 && c >= rst_c) begin
                if (c == rst_c) begin
                    chk($sformatf("k%0d_abort_tx", k), 32'(tx[k]), 1);
                    chk($sformatf("k%0d_abort_ready", k), 32'(ready[k]), 1);
                    chk($sformatf("k%0d_abort_done", k), 32'(done[k]), 0);
                end
                if (c == rst_c + rst_len - 1) begin
                    rst = 1'b0;
                    return;
                end
                continue;
            end
            if (en_now) t++;
            if (mode == 2 && cyc == 81) hold_tx = tx[k];
            if (mode == 2 && cyc == 181) chk($sformatf("k%0d_pause_hold", k), 32'(tx[k]), 32'(hold_tx));
            if (done[k]) begin
                got_done = 1'b1;
                break;
            end
            if (!ready[k]) low++;
            if (en_now && (t % osr) == osr / 2)
                chk($sformatf("k%0d_%h_bit%0d", k, d, t / osr), 32'(tx[k]), 32'(fr[t / osr]));
        end
        chk($sformatf("k%0d_done_seen_%h", k, d), 32'(got_done), 1);
        if (got_done) begin
            chk($sformatf("k%0d_done_cycle_%h", k, d), cyc, exp_done);
            chk($sformatf("k%0d_ready_low_%h", k, d), low, exp_done - 1);
            chk($sformatf("k%0d_ready_at_done_%h", k, d), 32'(ready[k]), 1);
            chk($sformatf("k%0d_total_ticks_%h", k, d), t, nb * osr);
            if (!chain) begin
                @(negedge clk);
                chk($sformatf("k%0d_done_drop_%h", k, d), 32'(done[k]), 0);
                chk($sformatf("k%0d_idle_tx_%h", k, d), 32'(tx[k]), 1);
            end
        end
    endtask

    initial begin
        int bad;
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            en[k]    = 1'b0;
            start[k] = 1'b0;
            data[k]  = 8'h00;
        end
        repeat (2) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("k%0d_reset_tx", k), 32'(tx[k]), 1);
            chk($sformatf("k%0d_reset_ready", k), 32'(ready[k]), 1);
            chk($sformatf("k%0d_reset_done", k), 32'(done[k]), 0);
        end
        rst = 1'b0;

        // Reset held three cycles mid-frame, then the line must stay idle.
        run_frame(0, 8'h55, -1, 16, 0, -1, 40, 3, 0, 1'b0);
        bad = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (tx[0] !== 1'b1 || ready[0] !== 1'b1 || done[0] !== 1'b0) bad++;
        end
        chk("k0_idle_after_reset", bad, 0);

        // Basic frame.
        run_frame(0, 8'h55, -1, 16, 0, -1, -1, 0, 177, 1'b0);

        // Parity frames: even A5 -> 0, odd A5 -> 1, odd 01 -> 0.
        run_frame(2, 8'hA5, 0, 16, 0, -1, -1, 0, 193, 1'b0);
        run_frame(1, 8'hA5, 1, 16, 0, -1, -1, 0, 193, 1'b0);
        run_frame(1, 8'h01, 0, 16, 0, -1, -1, 0, 193, 1'b0);

        // Busy rejection, then back-to-back acceptance in the done cycle.
        run_frame(0, 8'hFF, -1, 16, 0, 50, -1, 0, 177, 1'b1);
        run_frame(0, 8'h3C, -1, 16, 0, -1, -1, 0, 177, 1'b0);

        // Sparse enable, with and without a 100-cycle gap.
        run_frame(3, 8'h81, -1, 4, 1, -1, -1, 0, 177, 1'b0);
        run_frame(3, 8'h81, -1, 4, 2, -1, -1, 0, 277, 1'b0);

        // Reset during data bit 3, then a clean frame.
        run_frame(0, 8'hA5, -1, 16, 0, -1, 70, 1, 0, 1'b0);
        run_frame(0, 8'h0F, -1, 16, 0, -1, -1, 0, 177, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
